pc_gen: RTL
===========

Name: pc_gen

Overview:
Parametrised program-counter generator for the pipelined MIPS core. It replaces the plain stall/load PC register with on-chip next-PC selection. It sequences sequential fetch, branch and jump redirects, exception entry and exception return. It holds a one-entry pending-redirect buffer so redirects are not lost while fetch is stalled. It sits at the head of IF and feeds instruction-memory address and the IF/ID pipeline register.

Parameters:
XLEN, 32, address/PC width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded by reset
EXC_VECTOR, 32'h0000_0080, exception handler entry address
INSTR_BYTES, 4, sequential increment; power of two; alignment = log2(INSTR_BYTES) low bits

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
stall_pc  in  1  hold PC (hazard unit)
br_taken  in  1  EX-stage branch resolved taken
br_target  in  XLEN  branch target
jmp_req  in  1  ID-stage jump
jmp_target  in  XLEN  jump target
exc_req  in  1  exception raised
exc_pc  in  XLEN  PC of faulting instruction
eret_req  in  1  return from exception
pc_out  out  XLEN  current fetch address
pc_seq  out  XLEN  pc_out + INSTR_BYTES (combinational)
epc_out  out  XLEN  saved exception PC
pend_valid  out  1  pending redirect buffered
misalign_err  out  1  one-cycle pulse: misaligned redirect target trapped

Behaviour:
- Reset (rst=1 at clk edge): pc_out=RESET_VECTOR, epc_out=0, pend_valid=0, misalign_err=0. Reset overrides every other input. Reset mid-stall discards any pending redirect.
- Source priority, highest first: exc_req > eret_req > br_taken > jmp_req > pending > sequential.
- Sequential: pc_out <= pc_out + INSTR_BYTES, modulo 2^XLEN. 0xFFFF_FFFC wraps to 0x0000_0000.
- exc_req:
  - Applies even when stall_pc=1.
  - pc_out <= EXC_VECTOR; epc_out <= exc_pc.
  - Clears pend_valid.
- eret_req (no exc_req): pc_out <= epc_out. Obeys stall rules like br/jmp.
- Stall with no exc_req:
  - pc_out holds.
  - Any asserted eret/br/jmp is captured into the pending buffer (target + priority rank); pend_valid <= 1.
  - The buffer is overwritten only by a request of equal or higher rank. A lower-rank request is dropped.
  - An eret target is captured as the epc_out value at capture time.
- Stall released (stall_pc=0):
  - If pend_valid and a live redirect is present, the higher rank wins; on a tie the live input wins.
  - The winner loads pc_out; pend_valid <= 0 in the same cycle.
- Alignment:
  - Applies to any br/jmp/eret target (live or pending) with nonzero low log2(INSTR_BYTES) bits, at the point it would load pc_out.
  - pc_out <= EXC_VECTOR; epc_out <= offending target; misalign_err=1 for exactly that cycle.
  - exc_req in the same cycle takes precedence: epc_out <= exc_pc, no misalign_err.
- Latency: every redirect appears on pc_out one cycle after the qualifying edge. No combinational path from redirect inputs to pc_out. pc_seq is combinational from pc_out only.
- Simultaneous br_taken and jmp_req: branch wins and the jump is discarded, because the jump belongs to the younger instruction.
- RESET_VECTOR and EXC_VECTOR are treated as aligned; no check on them.

Test Plan:
- Reset then run: rst=1 for 2 cycles, then release, stall_pc=0 -> pc_out 0x0, 0x4, 0x8, 0xC on successive edges; pc_seq=pc_out+4.
- Stall then redirect capture: at pc_out=0x10, stall_pc=1 for 3 cycles with jmp_req=1, jmp_target=0x200 in the first cycle only -> pc_out stays 0x10 and pend_valid=1; after release, next edge pc_out=0x200 and pend_valid=0.
- Priority: br_taken=1 with br_target=0x40, jmp_req=1 with jmp_target=0x80, same cycle, no stall -> pc_out=0x40. Repeat under stall -> pending holds 0x40; a later jmp to 0x80 while still stalled is dropped.
- Exception overrides stall:
  - stall_pc=1, exc_req=1, exc_pc=0x24 -> next edge pc_out=0x80, epc_out=0x24, pend_valid=0.
  - Then eret_req=1 -> pc_out=0x24.
- Misaligned target: br_taken=1, br_target=0x102 -> pc_out=0x80, epc_out=0x102, misalign_err high for exactly 1 cycle.
- Wrap and reset-mid-stall:
  - Sequential run from 0xFFFF_FFF8 -> 0xFFFF_FFFC then 0x0.
  - Separately, with pend_valid=1, assert rst -> pc_out=RESET_VECTOR, pend_valid=0, and no redirect after release.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator at the head of IF: sequential fetch, branch/jump/eret
// redirects, exception entry, and a one-entry pending-redirect buffer for stalls.
module pc_gen #(
   parameter int               XLEN         = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0]  EXC_VECTOR   = 32'h0000_0080,
   parameter int               INSTR_BYTES  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_pc,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_target,
   input  logic            jmp_req,
   input  logic [XLEN-1:0] jmp_target,
   input  logic            exc_req,
   input  logic [XLEN-1:0] exc_pc,
   input  logic            eret_req,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_seq,
   output logic [XLEN-1:0] epc_out,
   output logic            pend_valid,
   output logic            misalign_err
);

   // Redirect rank: higher value wins. Exceptions bypass ranking entirely.
   localparam logic [1:0] RANK_NONE = 2'd0;
   localparam logic [1:0] RANK_JMP  = 2'd1;
   localparam logic [1:0] RANK_BR   = 2'd2;
   localparam logic [1:0] RANK_ERET = 2'd3;

   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_epc;
   logic            r_pend_valid;
   logic [1:0]      r_pend_rank;
   logic [XLEN-1:0] r_pend_target;
   logic            r_misalign;

   logic [1:0]      w_live_rank;
   logic [XLEN-1:0] w_live_target;
   logic            w_take_live;
   logic            w_redir_valid;
   logic [XLEN-1:0] w_redir_target;
   logic            w_redir_misaligned;
   logic [XLEN-1:0] w_pc_seq;

   assign w_pc_seq = r_pc + PC_STEP;

   // Best live request; an eret redirects to the EPC as it stands right now.
   always_comb begin
      w_live_rank   = RANK_NONE;
      w_live_target = '0;
      if (eret_req) begin
         w_live_rank   = RANK_ERET;
         w_live_target = r_epc;
      end else if (br_taken) begin
         w_live_rank   = RANK_BR;
         w_live_target = br_target;
      end else if (jmp_req) begin
         w_live_rank   = RANK_JMP;
         w_live_target = jmp_target;
      end
   end

   // A live request displaces the buffered one on equal or higher rank.
   assign w_take_live = (w_live_rank != RANK_NONE) &&
                        (!r_pend_valid || (w_live_rank >= r_pend_rank));

   assign w_redir_valid      = w_take_live || r_pend_valid;
   assign w_redir_target     = w_take_live ? w_live_target : r_pend_target;
   assign w_redir_misaligned = |(w_redir_target & ALIGN_MASK);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= RESET_VECTOR;
         r_epc         <= '0;
         r_pend_valid  <= 1'b0;
         r_pend_rank   <= RANK_NONE;
         r_pend_target <= '0;
         r_misalign    <= 1'b0;
      end else begin
         r_misalign <= 1'b0;
         if (exc_req) begin
            r_pc         <= EXC_VECTOR;
            r_epc        <= exc_pc;
            r_pend_valid <= 1'b0;
         end else if (stall_pc) begin
            if (w_take_live) begin
               r_pend_valid  <= 1'b1;
               r_pend_rank   <= w_live_rank;
               r_pend_target <= w_live_target;
            end
         end else begin
            r_pend_valid <= 1'b0;
            if (w_redir_valid) begin
               // A misaligned target traps instead of being fetched.
               if (w_redir_misaligned) begin
                  r_pc       <= EXC_VECTOR;
                  r_epc      <= w_redir_target;
                  r_misalign <= 1'b1;
               end else begin
                  r_pc <= w_redir_target;
               end
            end else begin
               r_pc <= w_pc_seq;
            end
         end
      end
   end

   assign pc_out       = r_pc;
   assign pc_seq       = w_pc_seq;
   assign epc_out      = r_epc;
   assign pend_valid   = r_pend_valid;
   assign misalign_err = r_misalign;

endmodule
